// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM responder: command encodings, mode-register
// field positions and the CAS-latency type.
package sdram_pkg;

    // Encodings of {ncs, nras, ncas, nwe}; only meaningful while ncs=0.
    typedef enum logic [3:0] {
        CMD_LOAD_MODE    = 4'b0000,
        CMD_AUTO_REFRESH = 4'b0001,
        CMD_PRECHARGE    = 4'b0010,
        CMD_ACTIVE       = 4'b0011,
        CMD_WRITE        = 4'b0100,
        CMD_READ         = 4'b0101,
        CMD_BURST_TERM   = 4'b0110,
        CMD_NOP          = 4'b0111
    } sdram_cmd_e;

    typedef logic [2:0] cl_t;

    localparam int  MODE_BL_LSB = 0;
    localparam int  MODE_BL_MSB = 2;
    localparam int  MODE_CL_LSB = 4;
    localparam int  MODE_CL_MSB = 6;
    localparam int  AP_BIT      = 10;
    localparam cl_t CL_RESET    = 3'd2;

    // Only single-word bursts with CL 2 or 3 are modelled.
    function automatic logic mode_valid(input cl_t bl, input cl_t cl);
        return (bl == 3'd0) && ((cl == 3'd2) || (cl == 3'd3));
    endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// Per-bank state of the SDRAM responder: open flag, open row and a saturating
// cycles-since-ACTIVE counter used for the RCD check.
module sdram_resp_bank
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 6,
    parameter int RCD      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                activate_i,
    input  logic                close_i,
    input  logic [ROW_BITS-1:0] row_i,
    output logic                open_o,
    output logic                rcd_met_o,
    output logic [ROW_BITS-1:0] row_o
);
    localparam int CW = $clog2(RCD + 1) + 1;

    logic                open_q;
    logic [ROW_BITS-1:0] row_q;
    logic [CW-1:0]       cnt_q;

    // The counter reads k at the k-th edge after ACTIVE, so "k < RCD" is a violation.
    always_ff @(posedge clk) begin
        if (reset) begin
            open_q <= 1'b0;
            row_q  <= '0;
            cnt_q  <= '0;
        end else if (activate_i) begin
            open_q <= 1'b1;
            row_q  <= row_i;
            cnt_q  <= CW'(1);
        end else begin
            if (close_i) begin
                open_q <= 1'b0;
            end
            if (cnt_q < CW'(RCD)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign open_o    = open_q;
    assign row_o     = row_q;
    assign rcd_met_o = (cnt_q >= CW'(RCD));

endmodule

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device responder: decodes the command bus, tracks banks,
// stores x16 data and returns read data after the programmed CAS latency.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 6,
    parameter int COL_BITS = 8,
    parameter int RCD      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cke,
    input  logic        ncs,
    input  logic        nras,
    input  logic        ncas,
    input  logic        nwe,
    input  logic [11:0] a,
    input  logic [1:0]  ba,
    input  logic        dqml,
    input  logic        dqmh,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        ready,
    output logic        cmd_err,
    output logic        timing_err,
    output logic [15:0] refresh_cnt
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;

    logic [3:0]          cmd_raw;
    logic                cmd_en, is_lmr, is_ref, is_pre, is_act, is_rd, is_wr, lmr_ok;
    logic [3:0]          bank_open, bank_rcd_met, bank_act, bank_close;
    logic [ROW_BITS-1:0] bank_row [4];
    logic                sel_open, act_ok, rw_ok, rd_ok, wr_ok, rd_pending;
    logic                cmd_err_d, timing_err_d;
    logic [AW-1:0]       addr;
    logic [15:0]         mem [2**AW];
    cl_t                 cl_q;
    logic                ready_q, cmd_err_q, timing_err_q, dq_oe_q;
    logic [15:0]         refresh_q, dq_out_q;
    logic                s1_v_q, s1_cl3_q, s2_v_q;
    logic [15:0]         s1_data_q, s2_data_q;
    logic                unused_a;

    assign cmd_raw  = {ncs, nras, ncas, nwe};
    assign cmd_en   = cke & ~ncs;
    assign is_lmr   = cmd_en && (cmd_raw == CMD_LOAD_MODE);
    assign is_ref   = cmd_en && (cmd_raw == CMD_AUTO_REFRESH);
    assign is_pre   = cmd_en && (cmd_raw == CMD_PRECHARGE);
    assign is_act   = cmd_en && (cmd_raw == CMD_ACTIVE);
    assign is_rd    = cmd_en && (cmd_raw == CMD_READ);
    assign is_wr    = cmd_en && (cmd_raw == CMD_WRITE);
    assign lmr_ok   = is_lmr && mode_valid(a[MODE_BL_MSB:MODE_BL_LSB], a[MODE_CL_MSB:MODE_CL_LSB]);
    assign unused_a = ^a;

    assign sel_open   = bank_open[ba];
    assign act_ok     = is_act & ready_q & ~sel_open;
    assign rw_ok      = (is_rd | is_wr) & ready_q & sel_open;
    assign rd_ok      = rw_ok & is_rd;
    assign wr_ok      = rw_ok & is_wr;
    // Read data is on the bus from the edge after the READ up to edge READ+CL.
    assign rd_pending = s1_v_q | s2_v_q | dq_oe_q;
    assign addr       = {ba, bank_row[ba], a[COL_BITS-1:0]};

    always_comb begin
        cmd_err_d = cmd_err_q;
        if (is_lmr && !lmr_ok)                          cmd_err_d = 1'b1;
        if ((is_act || is_rd || is_wr) && !ready_q)     cmd_err_d = 1'b1;
        if (is_act && ready_q && sel_open)              cmd_err_d = 1'b1;
        if ((is_rd || is_wr) && ready_q && !sel_open)   cmd_err_d = 1'b1;
        if (wr_ok && rd_pending)                        cmd_err_d = 1'b1;
        if (is_ref && (|bank_open))                     cmd_err_d = 1'b1;
        timing_err_d = timing_err_q | (rw_ok & ~bank_rcd_met[ba]);
    end

    for (genvar i = 0; i < 4; i++) begin : g_bank
        assign bank_act[i]   = act_ok && (ba == 2'(i));
        assign bank_close[i] = (is_pre && (a[AP_BIT] || (ba == 2'(i))))
                             || (rw_ok && a[AP_BIT] && (ba == 2'(i)));
        sdram_resp_bank #(
            .ROW_BITS(ROW_BITS),
            .RCD     (RCD)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .activate_i(bank_act[i]),
            .close_i   (bank_close[i]),
            .row_i     (a[ROW_BITS-1:0]),
            .open_o    (bank_open[i]),
            .rcd_met_o (bank_rcd_met[i]),
            .row_o     (bank_row[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cl_q         <= CL_RESET;
            ready_q      <= 1'b0;
            cmd_err_q    <= 1'b0;
            timing_err_q <= 1'b0;
            refresh_q    <= '0;
            dq_oe_q      <= 1'b0;
            dq_out_q     <= '0;
            s1_v_q       <= 1'b0;
            s1_cl3_q     <= 1'b0;
            s2_v_q       <= 1'b0;
        end else begin
            cmd_err_q    <= cmd_err_d;
            timing_err_q <= timing_err_d;
            if (lmr_ok) begin
                cl_q    <= a[MODE_CL_MSB:MODE_CL_LSB];
                ready_q <= 1'b1;
            end
            if (is_ref) begin
                refresh_q <= refresh_q + 16'd1;
            end
            // Each slot carries its own latency so a CL=2 slot leaves from stage 1.
            s1_v_q   <= rd_ok;
            s1_cl3_q <= (cl_q == 3'd3);
            s2_v_q   <= s1_v_q & s1_cl3_q;
            dq_oe_q  <= (s1_v_q & ~s1_cl3_q) | s2_v_q;
            if (s1_v_q && !s1_cl3_q) begin
                dq_out_q <= s1_data_q;
            end else if (s2_v_q) begin
                dq_out_q <= s2_data_q;
            end else begin
                dq_out_q <= '0;
            end
        end
    end

    // Storage and read-data staging are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok && !reset) begin
            if (!dqml) mem[addr][7:0]  <= dq_in[7:0];
            if (!dqmh) mem[addr][15:8] <= dq_in[15:8];
        end
        s1_data_q <= {dqmh ? 8'h00 : mem[addr][15:8], dqml ? 8'h00 : mem[addr][7:0]};
        s2_data_q <= s1_data_q;
    end

    assign dq_out      = dq_out_q;
    assign dq_oe       = dq_oe_q;
    assign ready       = ready_q;
    assign cmd_err     = cmd_err_q;
    assign timing_err  = timing_err_q;
    assign refresh_cnt = refresh_q;

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter ROW_BITS, default 6: low row-address bits stored.
REQ-002 SHALL have parameter COL_BITS, default 8: column-address bits stored.
REQ-003 SHALL have parameter RCD, default 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cke  input  1  clock enable; low means no command decoded.
REQ-007 SHALL have ports ncs, nras, ncas, nwe  input  1 each  command strobes {ncs,nras,ncas,nwe}.
REQ-008 SHALL have port a  input  12  multiplexed row/column/mode address.
REQ-009 SHALL have port ba  input  2  bank select.
REQ-010 SHALL have ports dqml, dqmh  input  1 each  byte masks, 1 = lane masked.
REQ-011 SHALL have port dq_in  input  16  write data.
REQ-012 SHALL have port dq_out  output  16  read data.
REQ-013 SHALL have port dq_oe  output  1  read-data drive enable.
REQ-014 SHALL have port ready  output  1  high after first valid LOAD_MODE.
REQ-015 SHALL have ports cmd_err, timing_err  output  1 each  sticky protocol and timing error flags.
REQ-016 SHALL have port refresh_cnt  output  16  AUTO_REFRESH count, wraps at 0xFFFF->0.

Function
REQ-017 SHALL decode commands only when cke=1 and ncs=0: NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, AUTO_REFRESH 0001, LOAD_MODE 0000; BURST_TERMINATE 0110 is treated as NOP.
REQ-018 SHALL accept LOAD_MODE only with a[2:0]=000 and a[6:4] in {2,3}; it latches CL=a[6:4] and sets ready; any other value sets cmd_err and leaves mode and ready unchanged.
REQ-019 SHALL treat ACTIVE, READ and WRITE issued while ready=0 as cmd_err and ignore them.
REQ-020 SHALL track per bank: open flag, row (a[ROW_BITS-1:0]), and a saturating cycles-since-ACTIVE counter.
REQ-021 SHALL treat ACTIVE to an open bank as cmd_err; the existing row stays open.
REQ-022 SHALL close bank ba on PRECHARGE with a[10]=0, and close all banks with a[10]=1; precharging a closed bank is legal.
REQ-023 SHALL treat READ/WRITE to a closed bank as cmd_err and ignore it.
REQ-024 SHALL set timing_err when READ/WRITE arrives fewer than RCD cycles after ACTIVE on that bank, and still perform the access.
REQ-025 SHALL form the word address as {ba, row, a[COL_BITS-1:0]} into 2^(2+ROW_BITS+COL_BITS) x16 storage.
REQ-026 SHALL, on WRITE sampled at edge t, write dq_in[7:0] if dqml=0 and dq_in[15:8] if dqmh=0; fully masked writes change nothing.
REQ-027 SHALL, on READ sampled at edge t, capture memory contents as of edge t and drive dq_out with dq_oe=1 for exactly one cycle, registered at edge t+CL-1; lanes with DQM=1 at edge t drive 0x00.
REQ-028 SHALL auto-precharge the accessed bank after READ/WRITE when a[10]=1.
REQ-029 SHALL treat WRITE sampled while a READ data slot is pending in the next CL cycles as cmd_err (bus conflict); the write is still performed.
REQ-030 SHALL treat AUTO_REFRESH with any bank open as cmd_err; refresh_cnt increments in all cases.
REQ-031 SHALL allow back-to-back READs every cycle; the read pipeline holds up to 3 in-flight slots.

Reset
REQ-032 SHALL on reset: close all banks, set CL=2, ready=0, cmd_err=0, timing_err=0, refresh_cnt=0, dq_oe=0, dq_out=0, and drop in-flight reads.
REQ-033 SHALL leave memory contents unchanged on reset.

Structure
REQ-034 SHALL place command encodings, mode-field bit positions and the CL type in shared package sdram_pkg.
REQ-035 SHALL instantiate 4x sub-module sdram_resp_bank, holding open/row/RCD-counter state.

Verification
REQ-036 SHALL cover: LOAD_MODE a=0x020, ACTIVE ba=1 row 5, WRITE col 0x10 dq_in=0xBEEF DQM=00 at +2, READ at +4 -> dq_oe=1, dq_out=0xBEEF at edge READ+1, no errors.
REQ-037 SHALL cover: CL=3, WRITE 0x1234, then WRITE 0xAB00 with dqml=1 to the same address, then READ -> 0xAB34 valid exactly 2 edges after the READ edge.
REQ-038 SHALL cover: READ 1 cycle after ACTIVE with RCD=2 -> timing_err=1, data still returned.
REQ-039 SHALL cover: READ to a closed bank, ACTIVE twice to bank 0, AUTO_REFRESH with bank 2 open -> cmd_err=1, refresh_cnt=1.
REQ-040 SHALL cover: READ with a[10]=1, then READ same bank -> second READ gives cmd_err; reset mid-read -> dq_oe stays 0, ready=0.
